// File: rtl/tl_grant_serializer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tl_grant_serializer_pkg                                                    |
// | Shared width helpers, state encoding and grant type codes.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package tl_grant_serializer_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // The counter keeps at least one bit so RATIO=1 still has a legal port.
    function automatic int cnt_width(input int ratio);
        return (ratio > 1) ? clog2(ratio) : 1;
    endfunction

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;

    localparam logic [3:0] c_GNT_VOLUNTARY_ACK  = 4'h0;
    localparam logic [3:0] c_GNT_PREFETCH_ACK   = 4'h1;
    localparam logic [3:0] c_GNT_PUT_ACK        = 4'h2;
    localparam logic [3:0] c_GNT_GET_DATA_BEAT  = 4'h3;
    localparam logic [3:0] c_GNT_GET_DATA_BLOCK = 4'h4;

endpackage
`default_nettype wire

// File: rtl/tl_grant_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tl_grant_serializer                                                        |
// | Splits one wide grant beat into RATIO narrow sub-beats, low slice first.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tl_grant_serializer
    import tl_grant_serializer_pkg::*;
#(
    parameter int OUT_DATA_W  = 64,
    parameter int RATIO       = 2,
    parameter int ADDR_BEAT_W = 3,
    parameter int CLIENT_ID_W = 1,
    parameter int MGR_ID_W    = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    output logic                                 io_in_ready,
    input  logic                                 io_in_valid,
    input  logic [ADDR_BEAT_W-1:0]               io_in_bits_addr_beat,
    input  logic [CLIENT_ID_W-1:0]               io_in_bits_client_xact_id,
    input  logic [MGR_ID_W-1:0]                  io_in_bits_manager_xact_id,
    input  logic                                 io_in_bits_is_builtin_type,
    input  logic [3:0]                           io_in_bits_g_type,
    input  logic                                 io_in_bits_has_data,
    input  logic [OUT_DATA_W*RATIO-1:0]          io_in_bits_data,
    input  logic                                 io_out_ready,
    output logic                                 io_out_valid,
    output logic [ADDR_BEAT_W+clog2(RATIO)-1:0]  io_out_bits_addr_beat,
    output logic [CLIENT_ID_W-1:0]               io_out_bits_client_xact_id,
    output logic [MGR_ID_W-1:0]                  io_out_bits_manager_xact_id,
    output logic                                 io_out_bits_is_builtin_type,
    output logic [3:0]                           io_out_bits_g_type,
    output logic [OUT_DATA_W-1:0]                io_out_bits_data,
    output logic [cnt_width(RATIO)-1:0]          io_cnt,
    output logic                                 io_done
);

    localparam int c_IN_DATA_W = OUT_DATA_W * RATIO;
    localparam int c_CNT_W     = cnt_width(RATIO);

    generate
        if (RATIO == 1) begin : g_flow
            assign io_in_ready                 = io_out_ready;
            assign io_out_valid                = io_in_valid;
            assign io_out_bits_addr_beat       = io_in_bits_addr_beat;
            assign io_out_bits_client_xact_id  = io_in_bits_client_xact_id;
            assign io_out_bits_manager_xact_id = io_in_bits_manager_xact_id;
            assign io_out_bits_is_builtin_type = io_in_bits_is_builtin_type;
            assign io_out_bits_g_type          = io_in_bits_g_type;
            assign io_out_bits_data            = io_in_bits_data;
            assign io_cnt                      = '0;
            assign io_done                     = 1'b1;
        end else begin : g_serial
            logic [0:0]             r_state;
            logic [c_CNT_W-1:0]     r_cnt;
            logic [ADDR_BEAT_W-1:0] r_addr_beat;
            logic [CLIENT_ID_W-1:0] r_client_id;
            logic [MGR_ID_W-1:0]    r_mgr_id;
            logic                   r_builtin;
            logic [3:0]             r_g_type;
            logic [c_IN_DATA_W-1:0] r_data;

            logic w_busy;
            logic w_last;
            logic w_in_fire;

            assign w_busy    = (r_state == c_ST_BUSY);
            assign w_last    = (r_cnt == c_CNT_W'(RATIO - 1));
            assign w_in_fire = io_in_valid && io_out_ready && !w_busy;

            // Sub-beat 0 leaves straight from the input, so the hold register
            // only has to supply slices 1..RATIO-1.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_state     <= c_ST_IDLE;
                    r_cnt       <= '0;
                    r_addr_beat <= '0;
                    r_client_id <= '0;
                    r_mgr_id    <= '0;
                    r_builtin   <= 1'b0;
                    r_g_type    <= '0;
                    r_data      <= '0;
                end else if (!w_busy) begin
                    if (w_in_fire && io_in_bits_has_data) begin
                        r_state     <= c_ST_BUSY;
                        r_cnt       <= c_CNT_W'(1);
                        r_addr_beat <= io_in_bits_addr_beat;
                        r_client_id <= io_in_bits_client_xact_id;
                        r_mgr_id    <= io_in_bits_manager_xact_id;
                        r_builtin   <= io_in_bits_is_builtin_type;
                        r_g_type    <= io_in_bits_g_type;
                        r_data      <= io_in_bits_data;
                    end
                end else if (io_out_ready) begin
                    if (w_last) begin
                        r_state <= c_ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
            end

            assign io_in_ready  = w_busy ? 1'b0 : io_out_ready;
            assign io_out_valid = w_busy | io_in_valid;

            assign io_out_bits_addr_beat = w_busy ? {r_addr_beat, r_cnt}
                                                  : {io_in_bits_addr_beat, {c_CNT_W{1'b0}}};
            assign io_out_bits_client_xact_id  = w_busy ? r_client_id : io_in_bits_client_xact_id;
            assign io_out_bits_manager_xact_id = w_busy ? r_mgr_id    : io_in_bits_manager_xact_id;
            assign io_out_bits_is_builtin_type = w_busy ? r_builtin   : io_in_bits_is_builtin_type;
            assign io_out_bits_g_type          = w_busy ? r_g_type    : io_in_bits_g_type;
            assign io_out_bits_data = w_busy ? r_data[int'(r_cnt)*OUT_DATA_W +: OUT_DATA_W]
                                             : io_in_bits_data[OUT_DATA_W-1:0];

            assign io_cnt  = w_busy ? r_cnt : '0;
            assign io_done = w_busy ? w_last : !io_in_bits_has_data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tl_grant_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tl_grant_serializer                                                     |
// | Random and directed stimulus on RATIO=2/4/1 instances against a queue model.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_tl_grant_serializer;
    import tl_grant_serializer_pkg::*;

    localparam int R[3]  = '{2, 4, 1};
    localparam int W[3]  = '{64, 16, 16};
    localparam int SH[3] = '{1, 2, 0};

    typedef struct {
        logic        valid;
        logic        ready;
        logic [7:0]  addr;
        logic        cid;
        logic [1:0]  mid;
        logic        bi;
        logic [3:0]  gt;
        logic [63:0] data;
        int          cnt;
        logic        done;
    } exp_t;

    exp_t q[3][$];

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, has_data, bi, out_ready, cid;
    logic [1:0]   mid;
    logic [2:0]   addr;
    logic [3:0]   gt;
    logic [127:0] din;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    logic        d2_in_ready, d2_out_valid, d2_cid, d2_bi, d2_done;
    logic [3:0]  d2_addr;
    logic [1:0]  d2_mid;
    logic [3:0]  d2_gt;
    logic [63:0] d2_data;
    logic [0:0]  d2_cnt;

    logic        d4_in_ready, d4_out_valid, d4_cid, d4_bi, d4_done;
    logic [4:0]  d4_addr;
    logic [1:0]  d4_mid;
    logic [3:0]  d4_gt;
    logic [15:0] d4_data;
    logic [1:0]  d4_cnt;

    logic        d1_in_ready, d1_out_valid, d1_cid, d1_bi, d1_done;
    logic [2:0]  d1_addr;
    logic [1:0]  d1_mid;
    logic [3:0]  d1_gt;
    logic [15:0] d1_data;
    logic [0:0]  d1_cnt;

    tl_grant_serializer #(.OUT_DATA_W(64), .RATIO(2)) u_dut2 (
        .clk(clk), .reset(rst), .io_in_ready(d2_in_ready), .io_in_valid(in_valid),
        .io_in_bits_addr_beat(addr), .io_in_bits_client_xact_id(cid),
        .io_in_bits_manager_xact_id(mid), .io_in_bits_is_builtin_type(bi),
        .io_in_bits_g_type(gt), .io_in_bits_has_data(has_data), .io_in_bits_data(din),
        .io_out_ready(out_ready), .io_out_valid(d2_out_valid), .io_out_bits_addr_beat(d2_addr),
        .io_out_bits_client_xact_id(d2_cid), .io_out_bits_manager_xact_id(d2_mid),
        .io_out_bits_is_builtin_type(d2_bi), .io_out_bits_g_type(d2_gt),
        .io_out_bits_data(d2_data), .io_cnt(d2_cnt), .io_done(d2_done));

    tl_grant_serializer #(.OUT_DATA_W(16), .RATIO(4)) u_dut4 (
        .clk(clk), .reset(rst), .io_in_ready(d4_in_ready), .io_in_valid(in_valid),
        .io_in_bits_addr_beat(addr), .io_in_bits_client_xact_id(cid),
        .io_in_bits_manager_xact_id(mid), .io_in_bits_is_builtin_type(bi),
        .io_in_bits_g_type(gt), .io_in_bits_has_data(has_data), .io_in_bits_data(din[63:0]),
        .io_out_ready(out_ready), .io_out_valid(d4_out_valid), .io_out_bits_addr_beat(d4_addr),
        .io_out_bits_client_xact_id(d4_cid), .io_out_bits_manager_xact_id(d4_mid),
        .io_out_bits_is_builtin_type(d4_bi), .io_out_bits_g_type(d4_gt),
        .io_out_bits_data(d4_data), .io_cnt(d4_cnt), .io_done(d4_done));

    tl_grant_serializer #(.OUT_DATA_W(16), .RATIO(1)) u_dut1 (
        .clk(clk), .reset(rst), .io_in_ready(d1_in_ready), .io_in_valid(in_valid),
        .io_in_bits_addr_beat(addr), .io_in_bits_client_xact_id(cid),
        .io_in_bits_manager_xact_id(mid), .io_in_bits_is_builtin_type(bi),
        .io_in_bits_g_type(gt), .io_in_bits_has_data(has_data), .io_in_bits_data(din[15:0]),
        .io_out_ready(out_ready), .io_out_valid(d1_out_valid), .io_out_bits_addr_beat(d1_addr),
        .io_out_bits_client_xact_id(d1_cid), .io_out_bits_manager_xact_id(d1_mid),
        .io_out_bits_is_builtin_type(d1_bi), .io_out_bits_g_type(d1_gt),
        .io_out_bits_data(d1_data), .io_cnt(d1_cnt), .io_done(d1_done));

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] slice_of(input int i, input int k);
        logic [127:0] d;
        logic [127:0] mask;
        d    = din >> (k * W[i]);
        mask = (128'd1 << W[i]) - 128'd1;
        return 64'(d & mask);
    endfunction

    // With nothing pending the instance is a pass-through of the current beat.
    function automatic exp_t expect_of(input int i);
        exp_t e;
        if (q[i].size() > 0) begin
            e = q[i][0];
        end else begin
            e.valid = in_valid;
            e.ready = out_ready;
            e.addr  = 8'(addr) << SH[i];
            e.cid   = cid;
            e.mid   = mid;
            e.bi    = bi;
            e.gt    = gt;
            e.data  = slice_of(i, 0);
            e.cnt   = 0;
            e.done  = !has_data || (R[i] == 1);
        end
        return e;
    endfunction

    task automatic cmp(input int i, input logic ready, input logic valid, input logic [7:0] a,
                       input logic c, input logic [1:0] m, input logic b, input logic [3:0] g,
                       input logic [63:0] d, input int n, input logic dn);
        exp_t e;
        string p;
        e = expect_of(i);
        p = $sformatf("r%0d.", R[i]);
        chk({p, "in_ready"}, 128'(ready), 128'(e.ready));
        chk({p, "out_valid"}, 128'(valid), 128'(e.valid));
        chk({p, "addr_beat"}, 128'(a), 128'(e.addr));
        chk({p, "client_id"}, 128'(c), 128'(e.cid));
        chk({p, "mgr_id"}, 128'(m), 128'(e.mid));
        chk({p, "builtin"}, 128'(b), 128'(e.bi));
        chk({p, "g_type"}, 128'(g), 128'(e.gt));
        chk({p, "data"}, 128'(d), 128'(e.data));
        chk({p, "cnt"}, 128'(n), 128'(e.cnt));
        chk({p, "done"}, 128'(dn), 128'(e.done));
    endtask

    // Inputs are already driven (after a negedge); compares, then advances the model.
    task automatic cycle_check(input bit do_rst);
        exp_t e;
        if (do_rst) begin
            rst = 1'b1;
            for (int i = 0; i < 3; i++) q[i].delete();
        end
        #1;
        cmp(0, d2_in_ready, d2_out_valid, 8'(d2_addr), d2_cid, d2_mid, d2_bi, d2_gt,
            d2_data, int'(d2_cnt), d2_done);
        cmp(1, d4_in_ready, d4_out_valid, 8'(d4_addr), d4_cid, d4_mid, d4_bi, d4_gt,
            64'(d4_data), int'(d4_cnt), d4_done);
        cmp(2, d1_in_ready, d1_out_valid, 8'(d1_addr), d1_cid, d1_mid, d1_bi, d1_gt,
            64'(d1_data), int'(d1_cnt), d1_done);
        if (!do_rst) begin
            for (int i = 0; i < 3; i++) begin
                if (q[i].size() > 0) begin
                    if (out_ready) void'(q[i].pop_front());
                end else if (in_valid && out_ready && has_data && R[i] > 1) begin
                    for (int k = 1; k < R[i]; k++) begin
                        e.valid = 1'b1;
                        e.ready = 1'b0;
                        e.addr  = (8'(addr) << SH[i]) | 8'(k);
                        e.cid   = cid;
                        e.mid   = mid;
                        e.bi    = bi;
                        e.gt    = gt;
                        e.data  = slice_of(i, k);
                        e.cnt   = k;
                        e.done  = (k == R[i] - 1);
                        q[i].push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic drive(input logic v, input logic hd, input logic [2:0] a,
                         input logic [3:0] g, input logic [127:0] d, input logic ordy);
        rst       = 1'b0;
        in_valid  = v;
        has_data  = hd;
        addr      = a;
        gt        = g;
        din       = d;
        out_ready = ordy;
        cid       = 1'b1;
        mid       = 2'd2;
        bi        = 1'b1;
    endtask

    initial begin
        int cnt_seq[6];
        logic [5:0] rdy_seq;
        cnt_seq = '{0, 1, 1, 1, 2, 3};
        rdy_seq = 6'b111001;

        rst = 1'b1; in_valid = 1'b0; has_data = 1'b0; bi = 1'b0; out_ready = 1'b0;
        cid = 1'b0; mid = '0; addr = '0; gt = '0; din = '0;

        // Reset state: pass-through valid, in_ready follows out_ready.
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b0;
        cycle_check(1'b1);
        chk("rst.out_valid", 128'(d2_out_valid), 128'd1);
        chk("rst.in_ready", 128'(d2_in_ready), 128'd0);
        chk("rst.cnt", 128'(d4_cnt), 128'd0);

        // RATIO=2 data beat, low slice first then high slice.
        @(negedge clk);
        drive(1'b1, 1'b1, 3'd3, c_GNT_GET_DATA_BLOCK,
              {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555}, 1'b1);
        cycle_check(1'b0);
        chk("p1.data0", 128'(d2_data), 128'h5555_5555_5555_5555);
        chk("p1.addr0", 128'(d2_addr), 128'd6);
        chk("p1.done0", 128'(d2_done), 128'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, c_GNT_PUT_ACK, '0, 1'b1);
        cycle_check(1'b0);
        chk("p1.data1", 128'(d2_data), 128'hAAAA_AAAA_AAAA_AAAA);
        chk("p1.addr1", 128'(d2_addr), 128'd7);
        chk("p1.cnt1", 128'(d2_cnt), 128'd1);
        chk("p1.done1", 128'(d2_done), 128'd1);
        chk("p1.in_ready1", 128'(d2_in_ready), 128'd0);
        chk("r1.done", 128'(d1_done), 128'd1);

        // RATIO=4 dataless grant: one beat, then ready again next cycle.
        @(negedge clk);
        cycle_check(1'b1);
        @(negedge clk);
        drive(1'b1, 1'b0, 3'd5, c_GNT_VOLUNTARY_ACK, 128'h1234_5678_9ABC_DEF0, 1'b1);
        cycle_check(1'b0);
        chk("p2.data", 128'(d4_data), 128'hDEF0);
        chk("p2.done", 128'(d4_done), 128'd1);
        chk("p2.addr", 128'(d4_addr), 128'd20);
        @(negedge clk);
        cycle_check(1'b0);
        chk("p2.in_ready_next", 128'(d4_in_ready), 128'd1);

        // RATIO=4 with stalls: sub-beats held until each fire.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 3'd2, c_GNT_GET_DATA_BEAT,
                  (c == 0) ? 128'h0004_0003_0002_0001 : 128'hFFFF_EEEE_DDDD_CCCC, rdy_seq[c]);
            cycle_check(1'b0);
            chk($sformatf("p3.cnt%0d", c), 128'(d4_cnt), 128'(cnt_seq[c]));
            chk($sformatf("p3.data%0d", c), 128'(d4_data), 128'(cnt_seq[c] + 1));
            if (c > 0) chk($sformatf("p3.in_ready%0d", c), 128'(d4_in_ready), 128'd0);
        end
        chk("p3.done", 128'(d4_done), 128'd1);

        // Reset landing mid-BUSY on the RATIO=2 instance.
        @(negedge clk);
        cycle_check(1'b1);
        @(negedge clk);
        drive(1'b1, 1'b1, 3'd1, c_GNT_GET_DATA_BLOCK, 128'h0F0F, 1'b1);
        cycle_check(1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, c_GNT_PUT_ACK, '0, 1'b0);
        cycle_check(1'b1);
        chk("p4.cnt", 128'(d2_cnt), 128'd0);
        chk("p4.out_valid", 128'(d2_out_valid), 128'd0);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst       = 1'b0;
            in_valid  = ($urandom_range(0, 9) < 7);
            has_data  = $urandom_range(0, 1) == 1;
            out_ready = ($urandom_range(0, 9) < 7);
            addr      = 3'($urandom);
            cid       = 1'($urandom);
            mid       = 2'($urandom);
            bi        = 1'($urandom);
            gt        = 4'($urandom_range(0, 4));
            din       = {$urandom, $urandom, $urandom, $urandom};
            cycle_check($urandom_range(0, 49) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tl_grant_serializer.md
# tl_grant_serializer

Parametrised grant-channel width serializer. It takes one wide grant beat of RATIO×OUT_DATA_W data bits and emits RATIO narrow sub-beats of OUT_DATA_W bits, least-significant slice first. The first sub-beat flows through combinationally from the input; the remaining slices come from a hold register. It sits between a wide outer memory/bus grant port and a narrower client grant port. With RATIO=1 it degenerates to a pure flow-through (cnt=0, done=1).

## Interface
Parameters:
- OUT_DATA_W, 64: width of each output data sub-beat.
- RATIO, 2: input/output width ratio; power of two, 1..16.
- ADDR_BEAT_W, 3: input addr_beat width.
- CLIENT_ID_W, 1: client_xact_id width.
- MGR_ID_W, 2: manager_xact_id width.
- Derived: IN_DATA_W = OUT_DATA_W*RATIO; CNT_W = max(1, clog2(RATIO)); OUT_BEAT_W = ADDR_BEAT_W + clog2(RATIO).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- io_in_ready  out  1  input handshake ready.
- io_in_valid  in  1  input beat valid.
- io_in_bits_addr_beat  in  ADDR_BEAT_W  wide beat index.
- io_in_bits_client_xact_id  in  CLIENT_ID_W  client transaction id.
- io_in_bits_manager_xact_id  in  MGR_ID_W  manager transaction id.
- io_in_bits_is_builtin_type  in  1  builtin grant flag.
- io_in_bits_g_type  in  4  grant type.
- io_in_bits_has_data  in  1  beat carries data; serialize only when 1.
- io_in_bits_data  in  IN_DATA_W  wide data.
- io_out_ready  in  1  downstream ready.
- io_out_valid  out  1  output sub-beat valid.
- io_out_bits_addr_beat  out  OUT_BEAT_W  {in addr_beat, cnt}.
- io_out_bits_client_xact_id / manager_xact_id / is_builtin_type / g_type  out  same widths  copied from the beat being sent.
- io_out_bits_data  out  OUT_DATA_W  current slice.
- io_cnt  out  CNT_W  index of the sub-beat on the output.
- io_done  out  1  the output beat is the last one for its input beat.

## Operation
- States: IDLE, BUSY. Internal cnt register, CNT_W bits. Hold register stores all in-bits; cleared on reset.
- IDLE: output mirrors input; out_valid=in_valid; io_cnt=0; data=in_data[OUT_DATA_W-1:0]; addr_beat={in_addr_beat, 0}; in_ready=out_ready.
- IDLE, in fire with has_data=1 and RATIO>1: latch input into the hold register; cnt←1; go to BUSY. done=0 for this sub-beat.
- IDLE, has_data=0: single output beat; data = low slice; done=1; stay in IDLE.
- BUSY: in_ready=0; out_valid=1; fields come from the hold register; data=hold_data[cnt*OUT_DATA_W +: OUT_DATA_W]; io_cnt=cnt.
- BUSY out fire: cnt←cnt+1. If cnt==RATIO-1: cnt←0, done=1, go to IDLE.
- BUSY with out_ready=0: all outputs stable (no change until the fire).
- io_done is combinational: (IDLE && (!has_data || RATIO==1)) || (BUSY && cnt==RATIO-1). It is not qualified by valid.
- RATIO=1: no state; identical to flow-through.

## Timing
- Reset values: state=IDLE, cnt=0, hold=0. During reset: io_out_valid=io_in_valid (pass-through), io_in_ready=io_out_ready, io_cnt=0.
- Latency: sub-beat 0 has zero-cycle latency. Sub-beat k appears no earlier than cycle k after the input fire. Minimum RATIO cycles per data beat at full out_ready.
- Throughput: a new input beat can be accepted in the cycle after the last sub-beat fire (the IDLE return). No back-to-back overlap.
- in_ready depends combinationally on out_ready in IDLE. There is no other combinational in→out ready path.
- Reset mid-BUSY: the remaining sub-beats are discarded; the next cycle is IDLE with cnt=0.
- cnt never wraps past RATIO-1.

## Structure
- Shared package: clog2 function, CNT_W/OUT_BEAT_W derivation, grant g_type constants for tests.
- No sub-module. A single always_ff covers state, cnt and hold. Slice selection is an indexed part-select.

## Test plan
- RATIO=2, data beat 0xAAAA…_5555… (128b), addr_beat=3, out_ready=1 -> two outputs: 0x5555… (addr 6, cnt 0, done 0), then 0xAAAA… (addr 7, cnt 1, done 1). in_ready low during the 2nd.
- RATIO=4, has_data=0, g_type=4'h0 -> exactly one output, data = low slice, cnt 0, done 1. Stays IDLE; the next input is accepted the following cycle.
- RATIO=4, out_ready toggled 1-0-0-1-1-1 -> four sub-beats in order. Outputs held stable while stalled. No input accepted until the final fire.
- RATIO=2, reset asserted asynchronously mid-BUSY (cnt=1) -> cnt=0, state IDLE, hold cleared. The second sub-beat is never emitted.
- RATIO=1 -> in_ready==out_ready, out equals in every cycle, io_cnt=0, io_done=1.
- Back-to-back data beats at RATIO=2, continuous valid/ready -> beats output at cycles 0,1,2,3. The 2nd input is accepted at cycle 2; ids and g_type track their own beat.
